// File: rtl/ci_initiator.sv
// ---------------------------------------------------------------------------
// ci_initiator
//
// CPU-side initiator for the custom-instruction (CI) interface. One request
// at a time is accepted from the execute stage. The initiator then broadcasts
// start / ciN / operands to the CI responders, waits for the shared done line,
// captures the shared result and hands it back to write-back with the
// destination tag. The CPU is stalled for the whole transaction.
//
// Optional feature macro: CI_TIMEOUT_EN
//   defined   : a WAIT that lasts TIMEOUT_CYCLES without done is aborted and
//               returns rspError=1, rspResult=0, lastLatency=TIMEOUT_CYCLES.
//   undefined : WAIT lasts until done; rspError is always 0.
//
// Ports
//   clock, reset            : clock (rising edge), async active-low reset
//   reqValid/reqReady       : request handshake from execute stage
//   reqCiN/ValueA/ValueB/Tag: request payload
//   ciStart                 : one-cycle start pulse to responders
//   ciN, ciValueA, ciValueB : ID and operands, held for the transaction
//   ciDone, ciResult        : OR-ed responder completion and result
//   rspValid/rspReady       : response handshake to write-back
//   rspResult/Tag/Error     : response payload
//   cpuStall                : high while a transaction is in flight
//   lastLatency             : start-to-done cycles of the last transaction
// ---------------------------------------------------------------------------
module ci_initiator #(
  parameter int         TAG_WIDTH      = 5,
  parameter logic [7:0] IDLE_CI_N      = 8'hFF,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic [7:0]           reqCiN,
  input  logic [31:0]          reqValueA,
  input  logic [31:0]          reqValueB,
  input  logic [TAG_WIDTH-1:0] reqTag,
  output logic                 ciStart,
  output logic [7:0]           ciN,
  output logic [31:0]          ciValueA,
  output logic [31:0]          ciValueB,
  input  logic                 ciDone,
  input  logic [31:0]          ciResult,
  output logic                 rspValid,
  input  logic                 rspReady,
  output logic [31:0]          rspResult,
  output logic [TAG_WIDTH-1:0] rspTag,
  output logic                 rspError,
  output logic                 cpuStall,
  output logic [15:0]          lastLatency
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RSP   = 2'd3
  } state_e;

`ifdef CI_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

  state_e               state_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [15:0]          cnt_q;
  logic                 ciStart_q;
  logic [7:0]           ciN_q;
  logic [31:0]          ciValueA_q;
  logic [31:0]          ciValueB_q;
  logic                 rspValid_q;
  logic [31:0]          rspResult_q;
  logic [TAG_WIDTH-1:0] rspTag_q;
  logic                 rspError_q;
  logic [15:0]          lastLatency_q;
  logic                 timeout_s;

  // Saturating +1 used by the latency counter and the captured latency.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // The counter holds k during the k-th WAIT cycle, so reaching the limit
  // means TIMEOUT_CYCLES full WAIT cycles have elapsed.
  assign timeout_s = TIMEOUT_EN & (cnt_q >= TO_LIM);

  // Transaction FSM with all responder and response outputs registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      tag_q         <= '0;
      cnt_q         <= 16'd0;
      ciStart_q     <= 1'b0;
      ciN_q         <= IDLE_CI_N;
      ciValueA_q    <= 32'd0;
      ciValueB_q    <= 32'd0;
      rspValid_q    <= 1'b0;
      rspResult_q   <= 32'd0;
      rspTag_q      <= '0;
      rspError_q    <= 1'b0;
      lastLatency_q <= 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // ciDone is deliberately ignored here.
          if (reqValid) begin
            state_q    <= S_ISSUE;
            ciStart_q  <= 1'b1;
            ciN_q      <= reqCiN;
            ciValueA_q <= reqValueA;
            ciValueB_q <= reqValueB;
            tag_q      <= reqTag;
            cnt_q      <= 16'd0;
          end
        end
        S_ISSUE: begin
          ciStart_q <= 1'b0;
          cnt_q     <= 16'd1;
          if (ciDone) begin
            // Combinational responder answered on the start cycle.
            state_q       <= S_RSP;
            rspValid_q    <= 1'b1;
            rspResult_q   <= ciResult;
            rspTag_q      <= tag_q;
            rspError_q    <= 1'b0;
            lastLatency_q <= 16'd1;
            ciN_q         <= IDLE_CI_N;
            ciValueA_q    <= 32'd0;
            ciValueB_q    <= 32'd0;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= sat_inc(cnt_q);
          if (ciDone) begin
            // A done in the timeout cycle still counts as normal completion.
            state_q       <= S_RSP;
            rspValid_q    <= 1'b1;
            rspResult_q   <= ciResult;
            rspTag_q      <= tag_q;
            rspError_q    <= 1'b0;
            lastLatency_q <= sat_inc(cnt_q);
            ciN_q         <= IDLE_CI_N;
            ciValueA_q    <= 32'd0;
            ciValueB_q    <= 32'd0;
          end else if (timeout_s) begin
            state_q       <= S_RSP;
            rspValid_q    <= 1'b1;
            rspResult_q   <= 32'd0;
            rspTag_q      <= tag_q;
            rspError_q    <= 1'b1;
            lastLatency_q <= TO_LIM;
            ciN_q         <= IDLE_CI_N;
            ciValueA_q    <= 32'd0;
            ciValueB_q    <= 32'd0;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_RSP: begin
          // ciDone is ignored; response payload holds until the handshake.
          if (rspReady) begin
            rspValid_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign reqReady    = (state_q == S_IDLE);
  assign cpuStall    = (state_q != S_IDLE);
  assign ciStart     = ciStart_q;
  assign ciN         = ciN_q;
  assign ciValueA    = ciValueA_q;
  assign ciValueB    = ciValueB_q;
  assign rspValid    = rspValid_q;
  assign rspResult   = rspResult_q;
  assign rspTag      = rspTag_q;
  assign rspError    = rspError_q;
  assign lastLatency = lastLatency_q;

endmodule
